// File: rtl/multiword_pkg.sv
// Shared types and defaults for the multi-word adder controller.
// State encoding, default sizes and index-width helper.
package multiword_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int N_DEF     = 10;
  localparam int WORDS_DEF = 4;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_add_ctrl_adder.sv
// N-bit ripple-carry adder, purely combinational.
// One full-adder cell per bit, carry chained LSB to MSB.
module multiword_add_ctrl_adder #(
  parameter int N = 10
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] o,
  output logic         co
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    o    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      o[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[N];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Word-serial multi-precision adder around one N-bit ripple adder.
// MULTIWORD_OVERFLOW_FLAG_EN enables the signed overflow flag.
module multiword_add_ctrl
  import multiword_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*WORDS-1:0] a_in,
  input  logic [N*WORDS-1:0] b_in,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] sum_out,
  output logic               cout,
  output logic               ovf
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [N-1:0]  a_w;
  logic [N-1:0]  b_w;
  logic [N-1:0]  o;
  logic          co;

  assign a_w = a_q[int'(idx)*N +: N];
  assign b_w = b_q[int'(idx)*N +: N];

  multiword_add_ctrl_adder #(
    .N(N)
  ) u_add (
    .a  (a_w),
    .b  (b_w),
    .cin(carry),
    .o  (o),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry   <= cin;
            idx     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_out[int'(idx)*N +: N] <= o;
          if (idx == LAST) begin
            cout  <= co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            carry <= co;
            idx   <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULTIWORD_OVERFLOW_FLAG_EN
  // Top word's adder output carries sum[W-1] on the final RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      ovf <= 1'b0;
    end else if (state == RUN && idx == LAST) begin
      ovf <= (a_q[W-1] == b_q[W-1]) && (o[N-1] != a_q[W-1]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed-vector bench for multiword_add_ctrl (N=10, WORDS=4).
// Outputs sampled on the falling edge.
module tb_multiword_add_ctrl;

  localparam int N = 10;
  localparam int WORDS = 4;
  localparam int W = N * WORDS;

`ifdef MULTIWORD_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multiword_add_ctrl #(
    .N(N),
    .WORDS(WORDS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .sum_out(sum_out),
    .cout   (cout),
    .ovf    (ovf)
  );

  // Issues one start, watches 8 cycles; reports first done cycle,
  // done/busy counts and the outputs seen at done.
  task automatic run_add(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c,
    output int           done_at,
    output int           done_cnt,
    output int           busy_cnt,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ov
  );
    done_at = 0;
    done_cnt = 0;
    busy_cnt = 0;
    s = 'x;
    co = 1'bx;
    ov = 1'bx;
    @(negedge clk);
    a_in = a;
    b_in = b;
    cin = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = '1;
    b_in = '1;
    cin = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = i;
          s = sum_out;
          co = cout;
          ov = ovf;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, cout, ovf} !== 4'b0 || sum_out !== '0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b cout=%b ovf=%b sum=%h",
               busy, done, cout, ovf, sum_out);
    end
  endtask

  task automatic test_ripple;
    int da, dc, bc;
    logic [W-1:0] s;
    logic co, ov;
    run_add(40'h00000003FF, 40'h0000000001, 1'b0,
            da, dc, bc, s, co, ov);
    tests++;
    if (s !== 40'h0000000400 || co !== 1'b0) begin
      fails++;
      $display("FAIL ripple: sum=%h cout=%b want 0000000400/0", s, co);
    end
    tests++;
    if (da != 5) begin
      fails++;
      $display("FAIL ripple_latency: done at %0d want 5", da);
    end
    tests++;
    if (sum_out !== 40'h0000000400) begin
      fails++;
      $display("FAIL ripple_hold: sum=%h want 0000000400", sum_out);
    end
  endtask

  task automatic test_all_ones;
    int da, dc, bc;
    logic [W-1:0] s;
    logic co, ov;
    run_add(40'hFFFFFFFFFF, 40'h0000000001, 1'b0,
            da, dc, bc, s, co, ov);
    tests++;
    if (s !== 40'h0 || co !== 1'b1) begin
      fails++;
      $display("FAIL all_ones: sum=%h cout=%b want 0/1", s, co);
    end
    tests++;
    if (bc != 4 || dc != 1) begin
      fails++;
      $display("FAIL all_ones_pulse: busy=%0d done=%0d want 4/1", bc, dc);
    end
  endtask

  task automatic test_cin_and_second;
    int da, dc, bc;
    logic [W-1:0] s;
    logic co, ov;
    run_add(40'h0, 40'h0, 1'b1, da, dc, bc, s, co, ov);
    tests++;
    if (s !== 40'h1 || co !== 1'b0) begin
      fails++;
      $display("FAIL cin: sum=%h cout=%b want 1/0", s, co);
    end
    run_add(40'h1234512345, 40'h0000100001, 1'b0,
            da, dc, bc, s, co, ov);
    tests++;
    if (s !== 40'h1234612346 || co !== 1'b0) begin
      fails++;
      $display("FAIL second: sum=%h cout=%b want 1234612346/0", s, co);
    end
  endtask

  task automatic test_start_ignored;
    int da = 0;
    @(negedge clk);
    a_in = 40'h1;
    b_in = 40'h1;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a_in = 40'h2;
    b_in = 40'h2;
    for (int i = 1; i <= 10 && da == 0; i++) begin
      @(negedge clk);
      if (done) da = i;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++;
    if (da != 5) begin
      fails++;
      $display("FAIL ignore_latency: done at %0d want 5", da);
    end
    @(negedge clk);
    tests++;
    if (sum_out !== 40'h2 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start: sum=%h busy=%b done=%b want 2/0/0",
               sum_out, busy, done);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int da, dc, bc;
    logic [W-1:0] s;
    logic co, ov;
    @(negedge clk);
    a_in = 40'hFFFFFFFFFF;
    b_in = 40'h1;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum_out !== '0 ||
        cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b",
               busy, done, sum_out, cout, ovf);
    end
    run_add(40'h5, 40'h7, 1'b0, da, dc, bc, s, co, ov);
    tests++;
    if (s !== 40'hC || co !== 1'b0 || da != 5) begin
      fails++;
      $display("FAIL after_reset: sum=%h cout=%b done@%0d want C/0/5",
               s, co, da);
    end
  endtask

  task automatic test_overflow;
    int da, dc, bc;
    logic [W-1:0] s;
    logic co, ov;
    run_add(40'h7FFFFFFFFF, 40'h1, 1'b0, da, dc, bc, s, co, ov);
    tests++;
    if (s !== 40'h8000000000 || co !== 1'b0 || ov !== OVF_EXP) begin
      fails++;
      $display("FAIL overflow: sum=%h cout=%b ovf=%b want 8000000000/0/%b",
               s, co, ov, OVF_EXP);
    end
    tests++;
    if (ovf !== OVF_EXP) begin
      fails++;
      $display("FAIL ovf_hold: ovf=%b want %b", ovf, OVF_EXP);
    end
    run_add(40'h3, 40'h4, 1'b0, da, dc, bc, s, co, ov);
    tests++;
    if (s !== 40'h7 || ov !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: sum=%h ovf=%b want 7/0", s, ov);
    end
  endtask

  initial begin
    test_reset;
    test_ripple;
    test_all_ones;
    test_cin_and_second;
    test_start_ignored;
    test_reset_mid;
    test_overflow;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
